// File: rtl/spi_req_arbiter.sv
// Two-requester round-robin front end that serialises byte transfers onto one SPI master.
// Define SPI_ARB_TIMEOUT_EN to add a WAIT_DONE watchdog (TIMEOUT_CYCLES) that answers 8'hFF with rsp_err.
module spi_req_arbiter #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       req0_valid,
  input  logic [7:0] req0_tx_data,
  input  logic [1:0] req0_mode,
  output logic       req0_ready,
  output logic       req0_rsp_valid,
  output logic [7:0] req0_rsp_data,
  input  logic       req1_valid,
  input  logic [7:0] req1_tx_data,
  input  logic [1:0] req1_mode,
  output logic       req1_ready,
  output logic       req1_rsp_valid,
  output logic [7:0] req1_rsp_data,
  output logic       rsp_err,
  output logic       m_start,
  output logic [7:0] m_tx_data,
  output logic       m_cpol,
  output logic       m_cpha,
  input  logic       m_ready,
  input  logic       m_done,
  input  logic [7:0] m_rx_data,
  output logic       busy,
  output logic       grant_id
);

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_DONE, RESPOND} state_t;

  state_t     state_reg;
  logic       last_grant_reg;
  logic       grant_reg;
  logic       start_reg;
  logic       busy_reg;
  logic       rsp0_reg;
  logic       rsp1_reg;
  logic       err_reg;
  logic       cpol_reg;
  logic       cpha_reg;
  logic [7:0] tx_reg;
  logic [7:0] rsp_data_reg;
  logic       pick;
  logic       accept;
  logic       timeout_hit;

  // Ready is a same-cycle handshake, so it is decoded from the registered state.
  always_comb begin
    pick = 1'b0;
    if (req0_valid && req1_valid) begin
      pick = ~last_grant_reg;
    end else if (req1_valid) begin
      pick = 1'b1;
    end
    accept = !reset && (state_reg == IDLE) && m_ready && (req0_valid || req1_valid);
  end

  assign req0_ready = accept && !pick;
  assign req1_ready = accept && pick;

`ifdef SPI_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt_reg;

  // Held at zero outside WAIT_DONE, so it is clear on every entry.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_reg <= '0;
    end else if (state_reg != WAIT_DONE) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  assign timeout_hit = (state_reg == WAIT_DONE) && (cnt_reg == TO_LAST);
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYCLES == 0);
  assign timeout_hit    = 1'b0;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg      <= IDLE;
      last_grant_reg <= 1'b1;
      grant_reg      <= 1'b0;
      start_reg      <= 1'b0;
      busy_reg       <= 1'b0;
      rsp0_reg       <= 1'b0;
      rsp1_reg       <= 1'b0;
      err_reg        <= 1'b0;
      cpol_reg       <= 1'b0;
      cpha_reg       <= 1'b0;
      tx_reg         <= 8'h00;
      rsp_data_reg   <= 8'h00;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            grant_reg <= pick;
            tx_reg    <= pick ? req1_tx_data : req0_tx_data;
            cpol_reg  <= pick ? req1_mode[1] : req0_mode[1];
            cpha_reg  <= pick ? req1_mode[0] : req0_mode[0];
            start_reg <= 1'b1;
            busy_reg  <= 1'b1;
            state_reg <= LAUNCH;
          end
        end
        LAUNCH: begin
          start_reg <= 1'b0;
          state_reg <= WAIT_DONE;
        end
        WAIT_DONE: begin
          // A real completion takes priority over a coincident timeout.
          if (m_done) begin
            rsp_data_reg <= m_rx_data;
            err_reg      <= 1'b0;
            rsp0_reg     <= !grant_reg;
            rsp1_reg     <= grant_reg;
            state_reg    <= RESPOND;
          end else if (timeout_hit) begin
            rsp_data_reg <= 8'hFF;
            err_reg      <= 1'b1;
            rsp0_reg     <= !grant_reg;
            rsp1_reg     <= grant_reg;
            state_reg    <= RESPOND;
          end
        end
        RESPOND: begin
          rsp0_reg       <= 1'b0;
          rsp1_reg       <= 1'b0;
          err_reg        <= 1'b0;
          busy_reg       <= 1'b0;
          last_grant_reg <= grant_reg;
          state_reg      <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign req0_rsp_valid = rsp0_reg;
  assign req1_rsp_valid = rsp1_reg;
  assign req0_rsp_data  = rsp_data_reg;
  assign req1_rsp_data  = rsp_data_reg;
  assign rsp_err        = err_reg;
  assign m_start        = start_reg;
  assign m_tx_data      = tx_reg;
  assign m_cpol         = cpol_reg;
  assign m_cpha         = cpha_reg;
  assign busy           = busy_reg;
  assign grant_id       = grant_reg;

endmodule

// File: doc/spi_req_arbiter.md
SPI_REQ_ARBITER -- requirements
Module: spi_req_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255, WAIT_DONE cycle limit; used only when SPI_ARB_TIMEOUT_EN is defined.
REQ-002 clock  in  1  single clock for the whole block; all logic on its rising edge.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 reqN_valid  in  1  requester N (N=0,1) has a byte to send.
REQ-005 reqN_tx_data  in  8  byte to transmit; valid while reqN_valid=1.
REQ-006 reqN_mode  in  2  {CPOL,CPHA} for this transfer.
REQ-007 reqN_ready  out  1  one-cycle accept pulse; the transfer is taken when valid and ready are both 1.
REQ-008 reqN_rsp_valid  out  1  one-cycle response pulse to requester N.
REQ-009 reqN_rsp_data  out  8  received byte; meaningful only while rsp_valid=1.
REQ-010 rsp_err  out  1  response carries a timeout error; shared by both requesters and qualified by reqN_rsp_valid.
REQ-011 m_start  out  1  one-cycle start pulse to the SPI master.
REQ-012 m_tx_data  out  8  byte presented to the master.
REQ-013 m_cpol, m_cpha  out  1 each  mode presented to the master.
REQ-014 m_ready  in  1  master idle and able to accept a start.
REQ-015 m_done  in  1  master transfer-complete pulse.
REQ-016 m_rx_data  in  8  master received byte; valid in the m_done cycle.
REQ-017 busy  out  1  high in every state except IDLE.
REQ-018 grant_id  out  1  index of the current or last granted requester.

Function
REQ-019 FSM states: IDLE, LAUNCH, WAIT_DONE, RESPOND. Transitions:
- IDLE->LAUNCH on accept.
- LAUNCH->WAIT_DONE always.
- WAIT_DONE->RESPOND on m_done (or on timeout).
- RESPOND->IDLE always.
REQ-020 Accept in IDLE requires m_ready=1 and at least one reqN_valid=1.
- The winner's reqN_ready=1 for that one cycle.
- tx_data, mode and id are latched on the same edge.
REQ-021 Arbitration, single valid: that requester wins.
REQ-022 Arbitration, both valid: round-robin; the requester not in last_grant wins.
REQ-023 m_ready=0 in IDLE: no reqN_ready is asserted and no state change occurs.
REQ-024 LAUNCH: m_start=1 for exactly one cycle.
REQ-025 m_tx_data, m_cpol and m_cpha hold the latched values from LAUNCH through RESPOND, with no glitches.
REQ-026 m_done is sampled only in WAIT_DONE; m_done in any other state is ignored.
REQ-027 In the WAIT_DONE cycle where m_done=1, m_rx_data is captured.
REQ-028 RESPOND: reqN_rsp_valid=1 for exactly one cycle, only for the granted N, with reqN_rsp_data equal to the captured byte.
REQ-029 last_grant is updated to the granted id in RESPOND.
REQ-030 Minimum latency from accept edge to rsp_valid is 3 cycles (m_done in the first WAIT_DONE cycle).
REQ-031 New requests arriving while busy=1 are not accepted; requesters hold valid until they see ready.
REQ-032 A non-granted requester's valid does not affect the transfer in progress.
REQ-033 At most one transfer is outstanding at any time.

Reset
REQ-034 Reset, asynchronous and active-high, forces:
- state=IDLE;
- all reqN_ready, reqN_rsp_valid, rsp_err, m_start and busy = 0;
- reqN_rsp_data, m_tx_data = 8'h00;
- m_cpol, m_cpha = 0;
- grant_id=0;
- last_grant=1, so req0 wins the first tie.
REQ-035 Reset asserted mid-transfer aborts silently: no rsp_valid is issued, and any later m_done is ignored in IDLE.

Configuration
REQ-036 Macro SPI_ARB_TIMEOUT_EN, when defined, adds a WAIT_DONE cycle counter that clears on entry to WAIT_DONE.
REQ-037 With SPI_ARB_TIMEOUT_EN defined: when the counter reaches TIMEOUT_CYCLES without m_done, the FSM goes to RESPOND with rsp_data=8'hFF and rsp_err=1.
REQ-038 With SPI_ARB_TIMEOUT_EN defined: m_done wins if it occurs in the same cycle as the timeout.
REQ-039 Without SPI_ARB_TIMEOUT_EN: no counter is built, rsp_err is tied 0, and the FSM waits in WAIT_DONE indefinitely.

Verification
REQ-040 Only req0 valid, tx=8'hA5, mode=2'b01, m_done after 16 cycles with rx=8'h3C -> req0_ready pulse; m_start one cycle later; m_cpha=1; req0_rsp_data=8'h3C for one cycle.
REQ-041 Both valid from reset, then both again -> req0 granted first, then req1; grant_id sequence 0,1.
REQ-042 req1 valid with m_ready=0 for 5 cycles -> no req1_ready until the cycle m_ready=1.
REQ-043 Reset asserted in WAIT_DONE, then m_done pulses -> no rsp_valid; busy=0; next request is serviced normally.
REQ-044 SPI_ARB_TIMEOUT_EN defined, TIMEOUT_CYCLES=8, m_done never pulses -> rsp_valid after 8 WAIT_DONE cycles with data 8'hFF and rsp_err=1.
REQ-045 m_done pulsed during LAUNCH -> ignored; FSM stays in WAIT_DONE until the next m_done.
